// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with busy scoreboard.
// Optional hardwired-zero register is enabled by defining REGFILE_ZERO_REG_EN.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = {ADDR_W_DEF{1'b0}};

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, with lookups for
// both read ports. REGFILE_ZERO_REG_EN keeps register 0 permanently not busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy
);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic             issue_ok_s;

    // Qualify issue: with a hardwired zero register, issuing to r0 never creates a producer
    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        issue_ok_s = issue_en && (issue_dst != ADDR_W'(REG_ZERO));
`else
        issue_ok_s = issue_en;
`endif
    end

    // Next busy vector: writeback clears, issue sets, set wins on the same index
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            busy_nxt_s[i] = (issue_ok_s && (issue_dst == ADDR_W'(i))) ||
                            (busy_r[i] && !(wr_en && (wr_addr == ADDR_W'(i))));
        end
    end

    // Busy bit storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // A same-cycle writeback hides the busy bit unless a new producer issues to the same index
    function automatic logic busy_view(input logic [ADDR_W-1:0] addr,
                                       input logic [DEPTH-1:0]  bits,
                                       input logic              we,
                                       input logic [ADDR_W-1:0] wa,
                                       input logic              ie,
                                       input logic [ADDR_W-1:0] id);
        logic b;
        b = bits[addr];
        if ((BYPASS != 0) && we && (wa == addr) && !(ie && (id == addr))) begin
            b = 1'b0;
        end else begin
            b = bits[addr];
        end
`ifdef REGFILE_ZERO_REG_EN
        if (addr == ADDR_W'(REG_ZERO)) begin
            b = 1'b0;
        end else begin
            b = b;
        end
`endif
        return b;
    endfunction

    // Read-port lookups and drain indicator
    always_comb begin
        busy_a   = busy_view(rd_addr_a, busy_r, wr_en, wr_addr, issue_en, issue_dst);
        busy_b   = busy_view(rd_addr_b, busy_r, wr_en, wr_addr, issue_en, issue_dst);
        any_busy = |busy_r;
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file (two async reads, one sync write, optional bypass) with a busy
// scoreboard for RAW hazard detection. REGFILE_ZERO_REG_EN hardwires register 0.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              any_busy
);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic              wr_ok_s;

    // Writes to a hardwired zero register are dropped and never forwarded
    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        wr_ok_s = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
`else
        wr_ok_s = wr_en;
`endif
    end

    // Register array storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Read port A with optional write forwarding
    always_comb begin
        rd_data_a = regs_r[rd_addr_a];
        if ((BYPASS != 0) && wr_ok_s && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr_a == ADDR_W'(REG_ZERO)) begin
            rd_data_a = {DATA_W{1'b0}};
        end else begin
            rd_data_a = rd_data_a;
        end
`endif
    end

    // Read port B with optional write forwarding
    always_comb begin
        rd_data_b = regs_r[rd_addr_b];
        if ((BYPASS != 0) && wr_ok_s && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr_b == ADDR_W'(REG_ZERO)) begin
            rd_data_b = {DATA_W{1'b0}};
        end else begin
            rd_data_b = rd_data_b;
        end
`endif
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .issue_en  (issue_en),
        .issue_dst (issue_dst),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .any_busy  (any_busy)
    );

endmodule
